fp_addsub_seq: RTL and testbench
================================

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a, b  input  W each  operands {sign, exp, frac}; sampled with start.
REQ-008 busy  output  1  high in every non-IDLE state.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 result  output  W  sum; valid from done, held until next accepted start.
REQ-011 ovf  output  1  overflow flag, valid with result.
REQ-012 unf  output  1  underflow/flush flag, valid with result.

Function
REQ-013 FSM states: IDLE, ALIGN, ADD, NORM, DONE; one transition maximum per clock.
REQ-014 IDLE + start: latch operands. Effective sign of b = b[W-1]^op_sub. Swap so A has the larger {exp,frac} magnitude. Load d = expA-expB. Go ALIGN. IDLE without start: stay.
REQ-015 start while busy is ignored; op_sub/a/b changes while busy have no effect.
REQ-016 Exp field 0 = zero (denormals flushed); exp field all-ones = infinity/NaN.
REQ-017 Special path: any all-ones-exp operand -> IDLE goes directly to DONE. Result = that infinity with its effective sign. Inf minus inf of equal magnitude -> {0, all-ones, 1 followed by zeros} (quiet NaN). ovf=unf=0.
REQ-018 Mantissa datapath: hidden bit + MAN_W + guard + round + sticky, plus one carry bit.
REQ-019 ALIGN: each cycle with count>0, shift B right 1, OR shifted-out bit into sticky, decrement count. count==0 -> ADD. Count loaded as min(d, MAN_W+3).
REQ-020 ADD: one cycle. Equal effective signs -> add; otherwise A-B. Result sign = sign of A.
REQ-021 NORM, evaluated in order:
- zero magnitude -> result +0, go DONE.
- carry set -> shift right 1 (sticky kept), exp+1, go DONE.
- hidden bit clear -> shift left 1, exp-1, stay in NORM.
- otherwise -> DONE.
REQ-022 Rounding: truncation (toward zero); guard/round/sticky discarded.
REQ-023 Exp reaching all-ones after carry -> result = signed infinity, ovf=1.
REQ-024 Exp reaching 0 during left shift -> result = signed zero, unf=1, go DONE.
REQ-025 DONE: done=1, result/ovf/unf updated, go IDLE next cycle.
REQ-026 Latency for normal operands = 4 + s + n cycles from the start-sampling edge to done high. s = alignment shifts; n = left-normalize shifts. Special path latency = 1.
REQ-027 Back-to-back: start may be asserted in the cycle after done and is accepted.

Reset
REQ-028 rst high at a clock edge forces IDLE in any state, including mid-operation. Outputs after reset: busy=0, done=0, result=0, ovf=0, unf=0; count and internal registers cleared.
REQ-029 rst has priority over start in the same cycle.
REQ-030 An operation interrupted by reset produces no done pulse.

Verification
REQ-031 a=0x3F800000, b=0x3F800000, op_sub=0 -> result 0x40000000, done 4 cycles after start, ovf=unf=0.
REQ-032 a=0x3F800000, b=0x3F400000, op_sub=1 -> result 0x3E800000 (s=1, n=2), done 7 cycles after start.
REQ-033 a=0x3FC00000, b=0x3FC00000, op_sub=1 -> result 0x00000000; a=0x3F800000, b=0x30800000 (d=30, s saturates at 26) -> result 0x3F800000.
REQ-034 a=0x7F7FFFFF, b=0x7F7FFFFF, op_sub=0 -> result 0x7F800000, ovf=1. a=0x7F800000, b=0x7F800000, op_sub=1 -> 0x7FC00000, done 1 cycle after start.
REQ-035 start pulsed again while busy -> ignored, single done, first result unchanged. rst asserted during ALIGN -> next cycle busy=0, result=0, no done.
REQ-036 Parameter sweep EXP_W=5, MAN_W=10: a=0x3C00, b=0x3C00, op_sub=0 -> 0x4000; random operands compared against a truncating reference model.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with truncating rounding.
// Denormals are flushed to zero; all-ones exponents are handled on a one-cycle special path.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   unf
);
  localparam int W         = 1 + EXP_W + MAN_W;
  localparam int MW        = MAN_W + 5;          // carry, hidden, fraction, guard, round, sticky
  localparam int CW        = $clog2(MAN_W + 4);
  localparam int MAX_SHIFT = MAN_W + 3;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t           stateReg, stateNext;
  logic             signReg, signNext;
  logic             effSubReg, effSubNext;
  logic [EXP_W-1:0] expReg, expNext;
  logic [MW-1:0]    manAReg, manANext;
  logic [MW-1:0]    manBReg, manBNext;
  logic [CW-1:0]    countReg, countNext;
  logic [W-1:0]     resultReg, resultNext;
  logic             ovfReg, ovfNext;
  logic             unfReg, unfNext;

  logic             signBEff, swap, bigSign, smallSign, special, nanCase;
  logic [W-2:0]     bigMag, smallMag;
  logic [EXP_W-1:0] bigExp, smallExp, expDiff, expInc, expDec;

  // Operand ordering: A is always the larger magnitude, so the subtraction never goes negative.
  always_comb begin
    signBEff  = b[W-1] ^ op_sub;
    swap      = b[W-2:0] > a[W-2:0];
    bigMag    = swap ? b[W-2:0] : a[W-2:0];
    smallMag  = swap ? a[W-2:0] : b[W-2:0];
    bigSign   = swap ? signBEff : a[W-1];
    smallSign = swap ? a[W-1] : signBEff;
    bigExp    = bigMag[W-2:MAN_W];
    smallExp  = smallMag[W-2:MAN_W];
    expDiff   = bigExp - smallExp;
    special   = (a[W-2:MAN_W] == EXP_ONES) || (b[W-2:MAN_W] == EXP_ONES);
    nanCase   = (smallExp == EXP_ONES) && (bigSign != smallSign) && (bigMag == smallMag);
    expInc    = expReg + 1'b1;
    expDec    = expReg - 1'b1;
  end

  always_comb begin
    stateNext  = stateReg;
    signNext   = signReg;
    effSubNext = effSubReg;
    expNext    = expReg;
    manANext   = manAReg;
    manBNext   = manBReg;
    countNext  = countReg;
    resultNext = resultReg;
    ovfNext    = ovfReg;
    unfNext    = unfReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          if (special) begin
            resultNext = nanCase ? {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}} : {bigSign, bigMag};
            ovfNext    = 1'b0;
            unfNext    = 1'b0;
            stateNext  = DONE;
          end else begin
            signNext   = bigSign;
            effSubNext = bigSign ^ smallSign;
            expNext    = bigExp;
            manANext   = (bigExp == '0) ? '0 : {2'b01, bigMag[MAN_W-1:0], 3'b000};
            manBNext   = (smallExp == '0) ? '0 : {2'b01, smallMag[MAN_W-1:0], 3'b000};
            countNext  = (int'(expDiff) > MAX_SHIFT) ? CW'(MAX_SHIFT) : CW'(expDiff);
            stateNext  = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (countReg != '0) begin
          manBNext  = {1'b0, manBReg[MW-1:2], |manBReg[1:0]};
          countNext = countReg - 1'b1;
        end else begin
          stateNext = ADD;
        end
      end
      ADD: begin
        manANext  = effSubReg ? manAReg - manBReg : manAReg + manBReg;
        stateNext = NORM;
      end
      NORM: begin
        if (manAReg == '0) begin
          resultNext = '0;
          ovfNext    = 1'b0;
          unfNext    = 1'b0;
          stateNext  = DONE;
        end else if (manAReg[MW-1]) begin
          // Carry out: the fraction after the right shift is simply one bit higher.
          manANext  = {1'b0, manAReg[MW-1:2], |manAReg[1:0]};
          expNext   = expInc;
          unfNext   = 1'b0;
          stateNext = DONE;
          if (expInc == EXP_ONES) begin
            resultNext = {signReg, EXP_ONES, {MAN_W{1'b0}}};
            ovfNext    = 1'b1;
          end else begin
            resultNext = {signReg, expInc, manAReg[MW-2:4]};
            ovfNext    = 1'b0;
          end
        end else if (!manAReg[MW-2]) begin
          manANext = manAReg << 1;
          expNext  = expDec;
          if (expDec == '0) begin
            resultNext = {signReg, {(W-1){1'b0}}};
            ovfNext    = 1'b0;
            unfNext    = 1'b1;
            stateNext  = DONE;
          end
        end else begin
          resultNext = {signReg, expReg, manAReg[MW-3:3]};
          ovfNext    = 1'b0;
          unfNext    = 1'b0;
          stateNext  = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg  <= IDLE;
      signReg   <= 1'b0;
      effSubReg <= 1'b0;
      expReg    <= '0;
      manAReg   <= '0;
      manBReg   <= '0;
      countReg  <= '0;
      resultReg <= '0;
      ovfReg    <= 1'b0;
      unfReg    <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      signReg   <= signNext;
      effSubReg <= effSubNext;
      expReg    <= expNext;
      manAReg   <= manANext;
      manBReg   <= manBNext;
      countReg  <= countNext;
      resultReg <= resultNext;
      ovfReg    <= ovfNext;
      unfReg    <= unfNext;
    end
  end

  assign busy   = (stateReg != IDLE);
  assign done   = (stateReg == DONE);
  assign result = resultReg;
  assign ovf    = ovfReg;
  assign unf    = unfReg;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: single-precision and a 16-bit (5/10) instance,
// directed corner cases plus random operands against an exact-arithmetic truncating model.
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        op0 = 1'b0, op1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, result0;
  logic [15:0] a1 = '0, b1 = '0, result1;
  logic        busy0, done0, ovf0, unf0;
  logic        busy1, done1, ovf1, unf1;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          startCyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_sub(op0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .result(result0), .ovf(ovf0), .unf(unf0)
  );

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .ovf(ovf1), .unf(unf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Exact sum of the two operand values, truncated toward zero. A smaller operand more
  // than MAN_W+4 binades below the larger one only matters as "nonzero and below half an
  // ulp", so its distance is capped there to keep the arithmetic inside 64 bits.
  function automatic logic [33:0] refModel(int ew, int mw, logic [31:0] a, logic [31:0] b, logic sub);
    int     w, p, e, dd;
    longint ones, fmask, mmask, magA, magB, magBig, magSmall, eBig, eSmall, ma, mb, r, res;
    logic   sA, sB, sBig, sSmall, isOvf, isUnf;
    w = 1 + ew + mw;
    ones  = (longint'(1) << ew) - 1;
    fmask = (longint'(1) << mw) - 1;
    mmask = (longint'(1) << (w - 1)) - 1;
    magA = longint'(a) & mmask;
    magB = longint'(b) & mmask;
    sA = a[w-1];
    sB = b[w-1] ^ sub;
    if (magB > magA) begin
      magBig = magB; magSmall = magA; sBig = sB; sSmall = sA;
    end else begin
      magBig = magA; magSmall = magB; sBig = sA; sSmall = sB;
    end
    eBig   = magBig >> mw;
    eSmall = magSmall >> mw;
    isOvf = 1'b0;
    isUnf = 1'b0;
    if (eBig == ones || eSmall == ones) begin
      if (eBig == ones && eSmall == ones && sBig != sSmall && magBig == magSmall)
        res = (ones << mw) | (longint'(1) << (mw - 1));
      else
        res = (longint'(sBig) << (w - 1)) | magBig;
      return {isOvf, isUnf, res[31:0]};
    end
    ma = (eBig == 0) ? 0 : ((longint'(1) << mw) | (magBig & fmask));
    mb = (eSmall == 0) ? 0 : ((longint'(1) << mw) | (magSmall & fmask));
    dd = int'(eBig - eSmall);
    if (dd > mw + 4) dd = mw + 4;
    r = (sBig == sSmall) ? (ma << (mw + 4)) + (mb << (mw + 4 - dd))
                         : (ma << (mw + 4)) - (mb << (mw + 4 - dd));
    if (r == 0) return 34'd0;
    p = -1;
    for (int i = 0; i < 63; i++) if (((r >> i) & 1) == 1) p = i;
    e = int'(eBig) + p - (2 * mw + 4);
    if (e >= int'(ones)) begin
      res = (longint'(sBig) << (w - 1)) | (ones << mw);
      isOvf = 1'b1;
    end else if (e <= 0) begin
      res = longint'(sBig) << (w - 1);
      isUnf = 1'b1;
    end else begin
      res = (longint'(sBig) << (w - 1)) | (longint'(e) << mw) | ((r >> (p - mw)) & fmask);
    end
    return {isOvf, isUnf, res[31:0]};
  endfunction

  function automatic logic busyOf(int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  task automatic waitIdle(int inst);
    int n = 0;
    while (busyOf(inst) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      $display("FAIL busy_timeout%0d: busy still high after %0d cycles, expected idle", inst, n);
    end
  endtask

  task automatic issue(int inst, logic [31:0] av, logic [31:0] bv, logic sub,
                       logic [31:0] expR, logic expO, logic expU, int expLat);
    exp_t item;
    waitIdle(inst);
    item.res = expR; item.ovf = expO; item.unf = expU; item.lat = expLat; item.startCyc = cyc;
    if (inst == 0) begin
      a0 = av; b0 = bv; op0 = sub; start0 = 1'b1;
      q0.push_back(item);
    end else begin
      a1 = av[15:0]; b1 = bv[15:0]; op1 = sub; start1 = 1'b1;
      q1.push_back(item);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic issueRef(int inst, logic [31:0] av, logic [31:0] bv, logic sub);
    logic [33:0] m;
    m = (inst == 0) ? refModel(8, 23, av, bv, sub) : refModel(5, 10, av, bv, sub);
    issue(inst, av, bv, sub, m[31:0], m[33], m[32], -1);
  endtask

  function automatic logic [31:0] randOperand(int ew, int mw, logic [31:0] near, bit useNear);
    int ones, ex, ne;
    logic [31:0] v;
    ones = (1 << ew) - 1;
    ne = int'((near >> mw) & ones);
    if (useNear) begin
      ex = ne + int'($urandom_range(0, 6)) - 3;
      if (ex < 1) ex = 1;
      if (ex > ones - 1) ex = ones - 1;
    end else if ($urandom_range(0, 9) == 0) begin
      ex = 0;
    end else begin
      ex = int'($urandom_range(1, ones - 1));
    end
    v = ($urandom() & ((32'd1 << mw) - 1)) | (32'(ex) << mw) | (32'($urandom_range(0, 1)) << (ew + mw));
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done0: result=%h with no pending request", result0);
      end else begin
        e = q0.pop_front();
        check("result0", longint'(result0), longint'(e.res));
        check("flags0", longint'({ovf0, unf0}), longint'({e.ovf, e.unf}));
        if (e.lat >= 0) check("latency0", longint'(cyc - e.startCyc), longint'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done1: result=%h with no pending request", result1);
      end else begin
        e = q1.pop_front();
        check("result1", longint'(result1), longint'(e.res[15:0]));
        check("flags1", longint'({ovf1, unf1}), longint'({e.ovf, e.unf}));
        if (e.lat >= 0) check("latency1", longint'(cyc - e.startCyc), longint'(e.lat));
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs0", longint'({busy0, done0, ovf0, unf0, result0}), 0);
    check("reset_outputs1", longint'({busy1, done1, ovf1, unf1, result1}), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);
    issue(0, 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 7);
    issue(0, 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0, 4);
    issue(0, 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 30);
    issue(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 4);
    issue(0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1);
    issue(0, 32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 1);
    issue(1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 1'b0, 1'b0, 4);
    issue(1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 1'b1, 1'b0, 4);

    // Start pulsed while busy must be ignored.
    issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);
    a0 = 32'h7F800000; b0 = 32'h7F800000; op0 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitIdle(0);
    @(negedge clk);

    // Reset mid-ALIGN, with start held high during reset.
    a0 = 32'h3F800000; b0 = 32'h30800000; op0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_in_align", longint'(busy0), 1);
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk);
    check("abort_busy", longint'(busy0), 0);
    check("abort_outputs", longint'({done0, ovf0, unf0, result0}), 0);
    rst = 1'b0; start0 = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_still_idle", longint'(busy0), 0);

    for (int i = 0; i < 250; i++) begin
      ra = randOperand(8, 23, 32'd0, 1'b0);
      rb = randOperand(8, 23, ra, ($urandom_range(0, 1) == 1));
      issueRef(0, ra, rb, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 250; i++) begin
      ra = randOperand(5, 10, 32'd0, 1'b0);
      rb = randOperand(5, 10, ra, ($urandom_range(0, 1) == 1));
      issueRef(1, ra, rb, 1'($urandom_range(0, 1)));
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("queues_drained", longint'(q0.size() + q1.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
